// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame geometry, scan-code type and the
// frame validity check used by the receiver.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef logic [PS2_DATA_BITS-1:0] scan_code_t;

    // Downstream stages treat this code as the key-release prefix.
    localparam scan_code_t PS2_BREAK_PREFIX = 8'hF0;

    // Odd parity across the data byte and its parity bit.
    function automatic logic odd_parity_ok(input scan_code_t code, input logic par);
        return ^{code, par};
    endfunction

    function automatic logic frame_ok(input logic start, input scan_code_t code,
                                      input logic par, input logic stop);
        return (start == 1'b0) && (stop == 1'b1) && odd_parity_ok(code, par);
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Brings raw ps2_clk/ps2_data into the clk domain and flags ps2_clk falling
// edges as a single-cycle pulse aligned with the synchronised data bit.
module ps2_edge_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic ps2_data_sync
);

    logic [2:0] clk_sync_r;
    logic [1:0] data_sync_r;

    // Idle level of both PS/2 lines is high, so the chains reset to ones.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_r  <= 3'b111;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    assign fall          = clk_sync_r[2] & ~clk_sync_r[1];
    assign ps2_data_sync = data_sync_r[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks them, and
// queues good scan codes in a show-ahead FIFO for the key-lookup stage.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic                      fall_s;
    logic                      data_s;
    logic [3:0]                bit_cnt_r;
    logic [PS2_DATA_BITS+1:0]  shift_r;
    logic [TO_W-1:0]           to_cnt_r;
    logic                      to_expire_s;
    logic                      frame_done_s;
    logic                      frame_good_s;
    logic                      push_r;
    scan_code_t                push_code_r;

    scan_code_t                mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    scan_code_t                data_r;
    logic                      ready_r;
    logic                      overflow_r;
    logic                      frame_err_r;

    logic                      pop_s;
    logic                      full_s;
    logic                      wr_en_s;
    logic                      ovf_set_s;
    logic [CNT_W-1:0]          count_nxt_s;
    logic [PTR_W-1:0]          rd_ptr_nxt_s;
    scan_code_t                data_nxt_s;

    ps2_edge_sync u_sync (
        .clk           (clk),
        .clrn          (clrn),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .fall          (fall_s),
        .ps2_data_sync (data_s)
    );

    // shift_r holds start/d/parity once ten bits are in; the stop bit is live data_s.
    assign frame_done_s = fall_s && (bit_cnt_r == LAST_BIT);
    assign frame_good_s = frame_ok(shift_r[0], shift_r[8:1], shift_r[9], data_s);
    assign to_expire_s  = (bit_cnt_r != 4'd0) && !fall_s &&
                          (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    // Bit counter and frame shift register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= '0;
        end else if (fall_s) begin
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= 4'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
                shift_r   <= {data_s, shift_r[PS2_DATA_BITS+1:1]};
            end
        end else if (to_expire_s) begin
            bit_cnt_r <= 4'd0;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Inactivity timer that abandons a stalled partial frame.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            to_cnt_r <= '0;
        end else if (fall_s || (bit_cnt_r == 4'd0) || to_expire_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Frame verdict register: push request for good frames, error pulse otherwise.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            push_r      <= 1'b0;
            push_code_r <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= frame_done_s & frame_good_s;
            push_code_r <= shift_r[8:1];
            frame_err_r <= frame_done_s & ~frame_good_s;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so full+pop still accepts.
    always_comb begin
        pop_s        = 1'b0;
        full_s       = 1'b0;
        wr_en_s      = 1'b0;
        ovf_set_s    = 1'b0;
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        data_nxt_s   = data_r;

        pop_s     = ~nextdata_n & (count_r != CNT_W'(0));
        full_s    = (count_r == CNT_W'(FIFO_DEPTH));
        wr_en_s   = push_r & (~full_s | pop_s);
        ovf_set_s = push_r & full_s & ~pop_s;

        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // The incoming code becomes the head only when the FIFO would otherwise be empty.
        if (count_nxt_s == CNT_W'(0)) begin
            data_nxt_s = data_r;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            data_nxt_s = push_code_r;
        end else begin
            data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            data_r     <= 8'h00;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_code_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            data_r     <= data_nxt_s;
            ready_r    <= (count_nxt_s != CNT_W'(0));
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    assign data      = data_r;
    assign ready     = ready_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are driven bit by bit, expected
// scan codes are queued, and a monitor checks every pop against the queue.
module tb_ps2_rx_fifo;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int         checks;
    int         failures;
    int         err_seen;
    int         exp_err;
    logic       exp_ovf;
    logic       frame_err_prev;
    logic [7:0] exp_q [$];

    ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYC(50000)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops are compared against the scoreboard; frame_err must be single-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_seen++;
            if (frame_err_prev === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL frame_err_width actual=2+cycles required=1cycle");
            end
        end
        frame_err_prev = frame_err;
        if (ready === 1'b1 && nextdata_n === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", data);
            end else begin
                logic [7:0] exp_code;
                exp_code = exp_q.pop_front();
                if (data !== exp_code) begin
                    failures++;
                    $display("FAIL pop_data actual=%0h required=%0h", data, exp_code);
                end
            end
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par);
        logic par;
        par = (~^d) ^ bad_par;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Drives nbits of a frame: data changes mid-high, ps2_clk low 20 / high 20.
    task automatic send_bits(input logic [10:0] frame, input int nbits, input bit chk_lat);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            ps2_data = frame[i];
            repeat (10) @(posedge clk);
            #1;
            ps2_clk = 1'b0;
            if (chk_lat && i == 10) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("latency_ready_low", ready, 1'b0);
                @(negedge clk);
                check("latency_ready_high", ready, 1'b1);
            end
            repeat (20) @(posedge clk);
            #1;
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        #1;
        ps2_data = 1'b1;
    endtask

    task automatic send_code(input logic [7:0] d, input bit bad_par, input bit chk_lat);
        send_bits(make_frame(d, bad_par), 11, chk_lat);
        if (bad_par) begin
            exp_err++;
        end else if (exp_q.size() < 8) begin
            exp_q.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        nextdata_n = 1'b0;
        @(posedge clk); #1;
        nextdata_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; err_seen = 0; exp_err = 0;
        exp_ovf = 1'b0; frame_err_prev = 1'b0;
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        clrn = 1'b1;

        // Reset and idle.
        for (int k = 0; k < 3; k++) begin
            repeat (15) @(negedge clk);
            check("idle_ready", ready, 1'b0);
            check("idle_data", data, 8'h00);
            check("idle_overflow", overflow, 1'b0);
            check("idle_frame_err", frame_err, 1'b0);
        end

        // Single code with latency check, then one pop empties the FIFO.
        send_code(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        check("single_data", data, 8'h1C);
        pop_one();
        @(negedge clk);
        check("single_ready_after_pop", ready, 1'b0);

        // Break sequence F0 1C.
        send_code(8'hF0, 1'b0, 1'b0);
        send_code(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("break_head", data, 8'hF0);
        check("break_ready", ready, 1'b1);
        pop_one();
        @(negedge clk);
        check("break_second", data, 8'h1C);
        pop_one();
        @(negedge clk);
        check("break_empty", ready, 1'b0);

        // Bad parity, then recovery.
        send_code(8'h1C, 1'b1, 1'b0);
        @(negedge clk);
        check("bad_ready", ready, 1'b0);
        check("bad_err_count", err_seen, exp_err);
        check("bad_overflow", overflow, 1'b0);
        send_code(8'h32, 1'b0, 1'b0);
        @(negedge clk);
        check("recover_data", data, 8'h32);
        pop_one();

        // Overflow: nine frames into eight slots.
        for (int k = 1; k <= 9; k++) begin
            send_code(8'(k), 1'b0, 1'b0);
        end
        @(negedge clk);
        check("ovf_flag", overflow, exp_ovf);
        check("ovf_head", data, 8'h01);
        for (int k = 0; k < 8; k++) begin
            pop_one();
        end
        @(negedge clk);
        check("ovf_drained", ready, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Partial frame abandoned by the timeout.
        send_bits(make_frame(8'h55, 1'b0), 5, 1'b0);
        repeat (50010) @(posedge clk);
        send_code(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("timeout_data", data, 8'h1C);
        check("timeout_no_err", err_seen, exp_err);
        pop_one();

        // Reset mid-frame with data queued and overflow set.
        send_code(8'h77, 1'b0, 1'b0);
        send_bits(make_frame(8'h21, 1'b0), 4, 1'b0);
        @(negedge clk);
        check("pre_reset_ready", ready, 1'b1);
        clrn = 1'b0;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        send_code(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_data", data, 8'h5A);
        pop_one();

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_count", err_seen, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
